// File: rtl/market_msg_decoder_if.sv
// rtl/market_msg_decoder_if.sv - byte stream interface from the UDP port filter
interface packet_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave (input data, input valid, output ready);
  modport DUT (input data, input valid, output ready);
endinterface

// File: rtl/market_msg_decoder.sv
// rtl/market_msg_decoder.sv - decodes 16-byte market messages into parallel records
module market_msg_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  packet_if.DUT            stream_in_if,
  input  logic             rec_ready,
  output logic             rec_valid,
  output logic [7:0]       rec_type,
  output logic [7:0]       rec_side,
  output logic [15:0]      rec_symbol,
  output logic [31:0]      rec_price,
  output logic [31:0]      rec_qty,
  output logic [31:0]      rec_seq,
  output logic             rec_seq_gap,
  output logic [CNT_W-1:0] err_unknown_cnt,
  output logic [CNT_W-1:0] err_trunc_cnt,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam logic [7:0] TYPE_ADD    = 8'h41;
  localparam logic [7:0] TYPE_CANCEL = 8'h58;
  localparam logic [7:0] TYPE_EXEC   = 8'h45;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISCARD} state_t;

  state_t      state;
  logic [3:0]  idx;
  logic [7:0]  stg_type;
  logic [7:0]  stg_side;
  logic [15:0] stg_symbol;
  logic [31:0] stg_price;
  logic [31:0] stg_qty;
  logic [23:0] stg_seq;
  logic        seq_seen;
  logic [31:0] exp_seq;

  logic        in_valid;
  logic [7:0]  in_data;
  logic        type_ok;
  logic        msg_done;
  logic        trunc_evt;
  logic        unknown_evt;
  logic        load_ok;
  logic [31:0] done_seq;

  // The filter is never back-pressured.
  assign stream_in_if.ready = 1'b1;

  // Event decode for the current byte; the last seq byte is merged directly.
  always_comb begin
    in_valid    = stream_in_if.valid;
    in_data     = stream_in_if.data;
    type_ok     = (in_data == TYPE_ADD) || (in_data == TYPE_CANCEL) || (in_data == TYPE_EXEC);
    msg_done    = (state == S_COLLECT) && in_valid && (idx == 4'd15);
    trunc_evt   = (state == S_COLLECT) && !in_valid;
    unknown_evt = (state == S_IDLE) && in_valid && !type_ok;
    load_ok     = !rec_valid || rec_ready;
    done_seq    = {stg_seq, in_data};
  end

  // Message framing FSM: byte index, state and staging capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      idx        <= 4'd0;
      stg_type   <= 8'd0;
      stg_side   <= 8'd0;
      stg_symbol <= 16'd0;
      stg_price  <= 32'd0;
      stg_qty    <= 32'd0;
      stg_seq    <= 24'd0;
    end else if (!in_valid) begin
      state <= S_IDLE;
      idx   <= 4'd0;
    end else begin
      idx <= idx + 4'd1;
      case (state)
        S_IDLE: begin
          stg_type <= in_data;
          state    <= type_ok ? S_COLLECT : S_DISCARD;
        end
        S_COLLECT: begin
          case (idx)
            4'd1:                      stg_side   <= in_data;
            4'd2, 4'd3:                stg_symbol <= {stg_symbol[7:0], in_data};
            4'd4, 4'd5, 4'd6, 4'd7:    stg_price  <= {stg_price[23:0], in_data};
            4'd8, 4'd9, 4'd10, 4'd11:  stg_qty    <= {stg_qty[23:0], in_data};
            4'd12, 4'd13, 4'd14:       stg_seq    <= {stg_seq[15:0], in_data};
            4'd15:                     state      <= S_IDLE;
            default:                   ;
          endcase
        end
        S_DISCARD: begin
          if (idx == 4'd15) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sequence tracking and the single-entry output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_seen    <= 1'b0;
      exp_seq     <= 32'd0;
      rec_valid   <= 1'b0;
      rec_type    <= 8'd0;
      rec_side    <= 8'd0;
      rec_symbol  <= 16'd0;
      rec_price   <= 32'd0;
      rec_qty     <= 32'd0;
      rec_seq     <= 32'd0;
      rec_seq_gap <= 1'b0;
    end else if (msg_done) begin
      seq_seen <= 1'b1;
      exp_seq  <= done_seq + 32'd1;
      if (load_ok) begin
        rec_valid   <= 1'b1;
        rec_type    <= stg_type;
        rec_side    <= stg_side;
        rec_symbol  <= stg_symbol;
        rec_price   <= stg_price;
        rec_qty     <= stg_qty;
        rec_seq     <= done_seq;
        rec_seq_gap <= seq_seen && (done_seq != exp_seq);
      end
    end else if (rec_valid && rec_ready) begin
      rec_valid <= 1'b0;
    end
  end

  // Saturating monitoring counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_unknown_cnt <= '0;
      err_trunc_cnt   <= '0;
      ovf_cnt         <= '0;
    end else begin
      if (unknown_evt && (err_unknown_cnt != '1)) err_unknown_cnt <= err_unknown_cnt + 1'b1;
      if (trunc_evt && (err_trunc_cnt != '1))     err_trunc_cnt   <= err_trunc_cnt + 1'b1;
      if (msg_done && !load_ok && (ovf_cnt != '1)) ovf_cnt        <= ovf_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_market_msg_decoder.sv
// tb/tb_market_msg_decoder.sv - scoreboard testbench for market_msg_decoder
module tb_market_msg_decoder;
  logic        clk = 1'b0;
  logic        reset;
  logic        rec_ready;
  logic        rec_valid;
  logic [7:0]  rec_type;
  logic [7:0]  rec_side;
  logic [15:0] rec_symbol;
  logic [31:0] rec_price;
  logic [31:0] rec_qty;
  logic [31:0] rec_seq;
  logic        rec_seq_gap;
  logic [15:0] err_unknown_cnt;
  logic [15:0] err_trunc_cnt;
  logic [15:0] ovf_cnt;

  packet_if pif ();

  market_msg_decoder #(.CNT_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .stream_in_if    (pif),
    .rec_ready       (rec_ready),
    .rec_valid       (rec_valid),
    .rec_type        (rec_type),
    .rec_side        (rec_side),
    .rec_symbol      (rec_symbol),
    .rec_price       (rec_price),
    .rec_qty         (rec_qty),
    .rec_seq         (rec_seq),
    .rec_seq_gap     (rec_seq_gap),
    .err_unknown_cnt (err_unknown_cnt),
    .err_trunc_cnt   (err_trunc_cnt),
    .ovf_cnt         (ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  t;
    logic [7:0]  side;
    logic [15:0] sym;
    logic [31:0] price;
    logic [31:0] qty;
    logic [31:0] seq;
    logic        gap;
  } rec_t;

  rec_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          m_seen = 1'b0;
  logic [31:0] m_exp = 32'd0;
  int          exp_unk = 0;
  int          exp_trunc = 0;
  int          exp_ovf = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Records are accepted on the edge after a negedge that sees valid & ready.
  always @(negedge clk) begin
    if (reset && rec_valid && rec_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_record", 64'd1, 64'd0);
      end else begin
        rec_t e;
        e = sb.pop_front();
        check("rec_type", rec_type, e.t);
        check("rec_side", rec_side, e.side);
        check("rec_symbol", rec_symbol, e.sym);
        check("rec_price", rec_price, e.price);
        check("rec_qty", rec_qty, e.qty);
        check("rec_seq", rec_seq, e.seq);
        check("rec_seq_gap", rec_seq_gap, e.gap);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    pif.data  = b;
    pif.valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic end_pkt();
    pif.valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic build(input logic [7:0] t, input logic [7:0] side, input logic [15:0] sym,
                       input logic [31:0] price, input logic [31:0] qty, input logic [31:0] seq,
                       output logic [7:0] b [16]);
    b[0] = t;
    b[1] = side;
    b[2] = sym[15:8];
    b[3] = sym[7:0];
    for (int k = 0; k < 4; k++) begin
      b[4 + k]  = price[31 - 8*k -: 8];
      b[8 + k]  = qty[31 - 8*k -: 8];
      b[12 + k] = seq[31 - 8*k -: 8];
    end
  endtask

  task automatic send_partial(input logic [7:0] t, input int n);
    logic [7:0] b [16];
    build(t, 8'h42, 16'h0002, 32'd55, 32'd66, 32'd77, b);
    for (int i = 0; i < n; i++) send_byte(b[i]);
  endtask

  task automatic send_msg(input logic [7:0] t, input logic [7:0] side, input logic [15:0] sym,
                          input logic [31:0] price, input logic [31:0] qty, input logic [31:0] seq,
                          input bit expect_out, input bit ready_at_last);
    logic [7:0] b [16];
    rec_t       e;
    bit         supported;
    build(t, side, sym, price, qty, seq, b);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        if (ready_at_last) rec_ready = 1'b1;
        if (expect_out && rec_ready && !ready_at_last) check("no_early_valid", rec_valid, 1'b0);
      end
      send_byte(b[i]);
    end
    supported = (t == 8'h41) || (t == 8'h58) || (t == 8'h45);
    if (supported) begin
      e.t = t; e.side = side; e.sym = sym; e.price = price; e.qty = qty; e.seq = seq;
      e.gap = m_seen && (seq != m_exp);
      m_seen = 1'b1;
      m_exp  = seq + 32'd1;
      if (expect_out) begin
        sb.push_back(e);
        check("latency_valid", rec_valid, 1'b1);
      end
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_unk"}, err_unknown_cnt, exp_unk);
    check({tag, "_trunc"}, err_trunc_cnt, exp_trunc);
    check({tag, "_ovf"}, ovf_cnt, exp_ovf);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, rec_valid, 1'b0);
    check({tag, "_fields"}, {rec_type, rec_side, rec_symbol, rec_seq_gap}, 33'd0);
    check({tag, "_price"}, rec_price, 32'd0);
    check({tag, "_qty"}, rec_qty, 32'd0);
    check({tag, "_seq"}, rec_seq, 32'd0);
    check_counters(tag);
  endtask

  initial begin
    int budget;
    pif.data  = 8'd0;
    pif.valid = 1'b0;
    rec_ready = 1'b1;
    reset     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;
    @(posedge clk);
    #1;

    // single add message
    send_msg(8'h41, 8'h42, 16'h0001, 32'd100, 32'd10, 32'd5, 1'b1, 1'b0);
    end_pkt();
    check_counters("single");

    // three back-to-back messages, last one skips a sequence number
    send_msg(8'h41, 8'h53, 16'h0010, 32'd200, 32'd1, 32'd7, 1'b1, 1'b0);
    send_msg(8'h58, 8'h42, 16'h0011, 32'd300, 32'd2, 32'd8, 1'b1, 1'b0);
    send_msg(8'h45, 8'h53, 16'h0012, 32'hDEADBEEF, 32'h01020304, 32'd10, 1'b1, 1'b0);
    end_pkt();

    // unknown type then a valid add in the same packet
    send_msg(8'h5A, 8'h42, 16'h0003, 32'd1, 32'd1, 32'd99, 1'b0, 1'b0);
    send_msg(8'h41, 8'h42, 16'h0004, 32'd400, 32'd4, 32'd11, 1'b1, 1'b0);
    end_pkt();
    exp_unk = 1;
    check_counters("unknown");

    // truncated message, then a full one in the next packet
    send_partial(8'h41, 9);
    end_pkt();
    exp_trunc = 1;
    check_counters("trunc");
    send_msg(8'h41, 8'h42, 16'h0005, 32'd500, 32'd5, 32'd12, 1'b1, 1'b0);
    end_pkt();

    // overflow while the consumer stalls
    rec_ready = 1'b0;
    send_msg(8'h41, 8'h42, 16'h0006, 32'd600, 32'd6, 32'd20, 1'b1, 1'b0);
    send_msg(8'h41, 8'h42, 16'h0007, 32'd700, 32'd7, 32'd21, 1'b0, 1'b0);
    exp_ovf = 1;
    check_counters("ovf");
    check("ovf_held_seq", rec_seq, 32'd20);
    check("ovf_held_price", rec_price, 32'd600);
    send_msg(8'h41, 8'h42, 16'h0008, 32'd800, 32'd8, 32'd22, 1'b1, 1'b1);
    end_pkt();
    check_counters("ovf_swap");

    // reset mid-message while a record is held
    rec_ready = 1'b0;
    send_msg(8'h41, 8'h42, 16'h0009, 32'd900, 32'd9, 32'd30, 1'b0, 1'b0);
    check("held_before_reset", rec_valid, 1'b1);
    send_partial(8'h41, 6);
    reset = 1'b0;
    #1;
    exp_unk = 0; exp_trunc = 0; exp_ovf = 0;
    check_reset_outputs("midreset");
    pif.valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    m_seen = 1'b0;
    m_exp  = 32'd0;
    rec_ready = 1'b1;
    send_msg(8'h41, 8'h42, 16'h000A, 32'd1000, 32'd11, 32'd100, 1'b1, 1'b0);
    end_pkt();
    check_counters("post_reset");

    budget = 0;
    while (sb.size() != 0 && budget < 40) begin
      @(posedge clk);
      budget++;
    end
    check("drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
